// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state codes, line levels, counter sizing.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
  localparam logic [2:0] ST_START  = 3'(S_START);
  localparam logic [2:0] ST_DATA   = 3'(S_DATA);
  localparam logic [2:0] ST_PARITY = 3'(S_PARITY);
  localparam logic [2:0] ST_STOP   = 3'(S_STOP);

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  // Width of a counter that must reach os-1; never narrower than one bit.
  function automatic int cnt_width(input int os);
    return (os <= 2) ? 1 : $clog2(os);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell timer: counts OVERSAMPLE cycles per cell, strobes cell_end on the last one.
// Latency: cell_end is combinational from the count; no backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic cell_end
);

  localparam int CW = cnt_width(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cell_end = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || !en || cell_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_xmit_param.sv
// UART transmitter with one-entry holding register; parity cell built with UART_XMIT_PARITY_EN.
// Latency: start bit appears 2 cycles after the accept edge; back-to-back frames have no gap.
// Backpressure: xmit_readyH low while the holding register is full; input ignored then.
module uart_xmit_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 xmit_validH,
  input  logic [DATA_BITS-1:0] xmit_dataH,
  output logic                 xmit_readyH,
  output logic                 uart_xmitH,
  output logic                 xmit_busyH,
  output logic                 xmit_doneH
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_xmit_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 256) begin : g_bad_oversample
    $error("uart_xmit_param: OVERSAMPLE must be 4..256");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_xmit_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_xmit_param: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_q, bit_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
`ifdef UART_XMIT_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic accept;
  logic load;
  logic cell_end;
  logic state_chg;
  logic last_data;
  logic last_stop;

  assign accept    = xmit_validH && !hold_full_q;
  assign state_chg = (state_d != state_q);
  assign last_data = (bit_q == 4'(DATA_BITS - 1));
  assign last_stop = (bit_q == 4'(STOP_BITS - 1));

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (state_q != ST_IDLE),
    .clr      (state_chg),
    .cell_end (cell_end)
  );

  // load marks every entry into START; that is the only hand-off from holding to shift register.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        if (cell_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cell_end && last_data) begin
`ifdef UART_XMIT_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_XMIT_PARITY_EN
      ST_PARITY: begin
        if (cell_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (cell_end && last_stop) begin
          if (hold_full_q) begin
            state_d = ST_START;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = xmit_dataH;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_d      = '0;
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = hold_q;
    end else if (state_q == ST_DATA && cell_end) begin
      shift_d = shift_q >> 1;
    end
  end

  always_comb begin
    bit_d = bit_q;
    if (state_chg) begin
      bit_d = '0;
    end else if (cell_end) begin
      bit_d = bit_q + 4'd1;
    end
  end

`ifdef UART_XMIT_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = (^hold_q) ^ (PARITY_ODD != 0);
    end
  end
`endif

  // The line and done flops follow state_q, so both trail the FSM by one cycle in step.
  always_comb begin
    line_d = HI;
    case (state_q)
      ST_START:  line_d = LO;
      ST_DATA:   line_d = shift_q[0];
`ifdef UART_XMIT_PARITY_EN
      ST_PARITY: line_d = parity_q;
`endif
      ST_STOP:   line_d = HI;
      default:   line_d = HI;
    endcase
  end

  always_comb begin
    done_d = (state_q == ST_STOP) && cell_end && last_stop;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      line_q      <= HI;
      done_q      <= 1'b0;
`ifdef UART_XMIT_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      line_q      <= line_d;
      done_q      <= done_d;
`ifdef UART_XMIT_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign xmit_readyH = !hold_full_q;
  assign uart_xmitH  = line_q;
  assign xmit_doneH  = done_q;
  // done_q covers the final stop cycle still on the line after the FSM has returned to IDLE.
  assign xmit_busyH  = (state_q != ST_IDLE) || hold_full_q || done_q;

endmodule

// File: doc/uart_xmit_param.md
UART_XMIT_PARAM -- requirements
Module: uart_xmit_param

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: sys_clk cycles per bit cell; legal range 4..256.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; meaningful only with UART_XMIT_PARITY_EN.
REQ-005 Clock and reset (already decided): one clock; reset is asynchronous and active-high.
REQ-006 Port sys_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port sys_rst, input, 1: asynchronous active-high reset.
REQ-008 Port xmit_validH, input, 1: request to send xmit_dataH.
REQ-009 Port xmit_dataH, input, DATA_BITS: word to send, LSB first.
REQ-010 Port xmit_readyH, output, 1: high when the holding register is empty.
REQ-011 Port uart_xmitH, output, 1: serial line; idle level high.
REQ-012 Port xmit_busyH, output, 1: high while a frame is on the line or a word is held.
REQ-013 Port xmit_doneH, output, 1: one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-014 Accept a word when xmit_validH and xmit_readyH are both high on a clock edge; the word goes into a one-entry holding register.
REQ-015 States are IDLE, START, DATA, PARITY and STOP; the FSM moves IDLE->START on the first cycle the holding register is full.
REQ-016 On entry to START, move the holding register into the shift register and free the holding register; xmit_readyH rises the next cycle.
REQ-017 Every bit cell lasts exactly OVERSAMPLE cycles, timed by a bit-cell counter that clears on every state change.
REQ-018 Bit order and levels: START drives 0; DATA drives the shift register LSB, shifting once per cell for DATA_BITS cells; PARITY drives one parity cell (macro only); STOP drives 1 for STOP_BITS cells.
REQ-019 Latency: a word accepted while IDLE with an empty holding register produces the start bit on uart_xmitH exactly 2 cycles after the accept edge.
REQ-020 On the last STOP cycle, go to START if the holding register is full (no idle gap between frames); otherwise go to IDLE.
REQ-021 When accept and transfer into the shift register occur on the same edge, the new word is held and never lost.
REQ-022 When xmit_validH is high and xmit_readyH is low, the input is ignored; the bench must hold xmit_validH until accepted.
REQ-023 uart_xmitH is driven from a register, so it is glitch-free.
REQ-024 Frame length is 1 + DATA_BITS + P + STOP_BITS cells, where P is 1 with parity enabled and 0 without.

Reset
REQ-025 While sys_rst is high: state=IDLE, uart_xmitH=1, xmit_readyH=1, xmit_busyH=0, xmit_doneH=0, counters=0, holding and shift registers=0.
REQ-026 Reset asserted mid-frame aborts the frame at once and drives uart_xmitH high asynchronously; no xmit_doneH pulse is produced.

Configuration
REQ-027 Macro UART_XMIT_PARITY_EN defined: the PARITY state is compiled in, and the parity bit is the XOR of the data bits, XORed with PARITY_ODD.
REQ-028 Macro UART_XMIT_PARITY_EN undefined: the PARITY state and parity logic are absent, and DATA goes directly to STOP.

Structure
REQ-029 Shared package uart_pkg holds the state enum, the LO/HI constants and a function giving counter width from OVERSAMPLE.
REQ-030 Sub-module uart_bit_timer holds the bit-cell counter; it has a clear input and produces a cell_end strobe.

Verification
REQ-031 Defaults, send 0xA5: line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; xmit_doneH pulses once at cycle 160 of the frame.
REQ-032 Back-to-back 0x00 then 0xFF, second accepted during the first frame: no idle cycle between frames; two xmit_doneH pulses 160 cycles apart.
REQ-033 UART_XMIT_PARITY_EN, PARITY_ODD=0, send 0x07: parity cell = 1; frame is 11 cells = 176 cycles.
REQ-034 DATA_BITS=5, STOP_BITS=2, OVERSAMPLE=4, send 0x1F: frame is 32 cycles; line high for the last 8 cycles.
REQ-035 Assert sys_rst at cycle 50 of a frame: uart_xmitH=1 within the same cycle, xmit_readyH=1, no xmit_doneH; the next send is a normal frame.
REQ-036 Hold xmit_validH while the holding register is full: xmit_readyH=0, and the data takes effect only on the accept edge after xmit_readyH rises.
